// File: rtl/disp_pkg.sv
// disp_pkg: shared scan-state type, register bundle, default timing and
// helpers for the 4-digit 7-segment scan controller.
package disp_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    typedef struct packed {
        logic [15:0] num;
        logic [3:0]  points;
        logic [3:0]  les;
    } disp_regs_t;

    localparam int SCAN_DIV_DEF     = 131072;
    localparam int BLANK_CYC_DEF    = 1024;
    localparam int BLINK_FRAMES_DEF = 64;

    // Anode select per digit index, active-low.
    localparam logic [3:0] AN_PATTERN [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    localparam logic [3:0] AN_OFF         = 4'hF;

    localparam disp_regs_t REGS_RESET = '{num: 16'h0000, points: 4'h0, les: 4'hF};

    // Bits needed for a counter running 0..div-1 (never narrower than one bit).
    function automatic int cnt_width(input int div);
        int w;
        if (div > 2) begin
            w = $clog2(div);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// disp_scan_ctrl_if: valid/ready write port carrying the next display contents.
interface disp_scan_ctrl_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_num;
    logic [3:0]  wr_points;
    logic [3:0]  wr_les;
    logic [3:0]  wr_blink;

    modport master (
        output wr_valid, wr_num, wr_points, wr_les, wr_blink,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_num, wr_points, wr_les, wr_blink,
        output wr_ready
    );
endinterface

// File: rtl/disp_scan_timer.sv
// disp_scan_timer: per-digit slot timing (BLANK then DRIVE), digit index and
// the combinational frame-end strobe marking the last DRIVE cycle of digit 3.
module disp_scan_timer
    import disp_pkg::*;
#(
    parameter int SCAN_DIV  = SCAN_DIV_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output scan_state_e state_r,
    output logic [1:0]  digit_r,
    output logic        frame_end_s
);

    localparam int CNT_W     = cnt_width(SCAN_DIV);
    localparam int DRIVE_CYC = SCAN_DIV - BLANK_CYC;
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYC - 1);
    // With no blanking interval every slot starts straight in DRIVE.
    localparam scan_state_e SLOT_START = (BLANK_CYC == 0) ? DRIVE : BLANK;

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    scan_state_e      state_nx_s;
    logic [1:0]       digit_nx_s;

    // Next-state logic: advance within the slot, roll digit at end of DRIVE.
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_r;
        digit_nx_s  = digit_r;
        frame_end_s = 1'b0;
        if (en) begin
            case (state_r)
                BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        state_nx_s = DRIVE;
                        cnt_nx_s   = CNT_ZERO;
                    end else begin
                        cnt_nx_s = cnt_r + CNT_ONE;
                    end
                end
                DRIVE: begin
                    if (cnt_r == DRIVE_LAST) begin
                        state_nx_s  = SLOT_START;
                        cnt_nx_s    = CNT_ZERO;
                        digit_nx_s  = digit_r + 2'd1;
                        frame_end_s = (digit_r == 2'd3);
                    end else begin
                        cnt_nx_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_nx_s = SLOT_START;
                    cnt_nx_s   = CNT_ZERO;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // State, slot counter and digit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= SLOT_START;
            cnt_r   <= CNT_ZERO;
            digit_r <= 2'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            digit_r <= digit_nx_s;
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 4-digit 7-segment scan controller with double-buffered
// display registers committed at frame ends. Optional blink: DISP_BLINK_EN.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int SCAN_DIV     = SCAN_DIV_DEF,
    parameter int BLANK_CYC    = BLANK_CYC_DEF,
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    disp_scan_ctrl_if.slave  wr_if,
    output logic [3:0]       an,
    output logic [3:0]       hex,
    output logic             le,
    output logic             point,
    output logic             frame_tick
);

    scan_state_e state_s;
    logic [1:0]  digit_s;
    logic        frame_end_s;

    disp_regs_t  shadow_r;
    disp_regs_t  active_r;
    logic        pending_r;
    logic        accept_s;
    logic        commit_s;
    logic [3:0]  blink_mask_s;

    logic [1:0]  lane_s;
    logic [3:0]  an_sel_s;
    logic [3:0]  hex_sel_s;
    logic        le_sel_s;
    logic        point_sel_s;

    logic [3:0]  an_r;
    logic [3:0]  hex_r;
    logic        le_r;
    logic        point_r;
    logic        frame_tick_r;

    disp_scan_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .state_r     (state_s),
        .digit_r     (digit_s),
        .frame_end_s (frame_end_s)
    );

    // Accept and commit can never coincide: accept needs pending low.
    assign accept_s       = wr_if.wr_valid & ~pending_r;
    assign commit_s       = frame_end_s & pending_r;
    assign wr_if.wr_ready = ~pending_r;

    // Shadow capture on accept, shadow-to-active transfer at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r  <= REGS_RESET;
            active_r  <= REGS_RESET;
            pending_r <= 1'b0;
        end else if (commit_s) begin
            active_r  <= shadow_r;
            pending_r <= 1'b0;
        end else if (accept_s) begin
            shadow_r  <= '{num: wr_if.wr_num, points: wr_if.wr_points, les: wr_if.wr_les};
            pending_r <= 1'b1;
        end
    end

`ifdef DISP_BLINK_EN
    localparam int BLINK_W = cnt_width(BLINK_FRAMES);
    localparam logic [BLINK_W-1:0] BLINK_ZERO = {BLINK_W{1'b0}};
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1'b1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [3:0]         shadow_blink_r;
    logic [3:0]         active_blink_r;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic               blink_phase_r;

    // Blink mask rides the same shadow/commit path as the other fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_blink_r <= 4'h0;
            active_blink_r <= 4'h0;
        end else if (commit_s) begin
            active_blink_r <= shadow_blink_r;
        end else if (accept_s) begin
            shadow_blink_r <= wr_if.wr_blink;
        end
    end

    // Blink phase flips after every BLINK_FRAMES frame ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_r   <= BLINK_ZERO;
            blink_phase_r <= 1'b0;
        end else if (frame_end_s) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r   <= BLINK_ZERO;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + BLINK_ONE;
            end
        end
    end

    assign blink_mask_s = active_blink_r & {4{blink_phase_r}};
`else
    logic unused_blink_s;
    assign unused_blink_s = ^wr_if.wr_blink;
    assign blink_mask_s   = 4'h0;
`endif

    // Digit mux; BLANK keeps anodes off but already carries the upcoming digit.
    always_comb begin
        lane_s      = 2'd3 - digit_s;
        hex_sel_s   = active_r.num[{lane_s, 2'b00} +: 4];
        le_sel_s    = active_r.les[lane_s] | blink_mask_s[lane_s];
        point_sel_s = active_r.points[lane_s];
        if (en && (state_s == DRIVE)) begin
            an_sel_s = AN_PATTERN[digit_s];
        end else begin
            an_sel_s = AN_OFF;
        end
    end

    // Output registers: one cycle behind the scan state.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_r         <= AN_OFF;
            hex_r        <= 4'h0;
            le_r         <= 1'b1;
            point_r      <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            an_r         <= an_sel_s;
            hex_r        <= hex_sel_s;
            le_r         <= le_sel_s;
            point_r      <= point_sel_s;
            frame_tick_r <= frame_end_s;
        end
    end

    assign an         = an_r;
    assign hex        = hex_r;
    assign le         = le_r;
    assign point      = point_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed bench for disp_scan_ctrl with a frame-position
// reference model checked every cycle plus hand-computed literal checkpoints.
module tb_disp_scan_ctrl;
    import disp_pkg::*;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] an;
    logic [3:0] hex;
    logic       le;
    logic       point;
    logic       frame_tick;

    disp_scan_ctrl_if wr_if ();

    disp_scan_ctrl #(
        .SCAN_DIV     (SD),
        .BLANK_CYC    (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wr_if      (wr_if),
        .an         (an),
        .hex        (hex),
        .le         (le),
        .point      (point),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Reference model: position within the frame counts enabled cycles.
    bit          m_valid = 1'b0;
    int          m_pos;
    logic [15:0] s_num, a_num;
    logic [3:0]  s_pts, a_pts, s_les, a_les, s_blk, a_blk;
    bit          m_pending;
    bit          m_phase;
    int          m_bcnt;
    logic [3:0]  e_an, e_hex;
    logic        e_le, e_point, e_tick;

    always @(posedge clk) begin
        int dig;
        int off;
        bit fe;
        bit acc;
        if (rst) begin
            m_valid = 1'b1;
            m_pos = 0; m_pending = 1'b0; m_phase = 1'b0; m_bcnt = 0;
            s_num = 16'h0; a_num = 16'h0; s_pts = 4'h0; a_pts = 4'h0;
            s_les = 4'hF; a_les = 4'hF; s_blk = 4'h0; a_blk = 4'h0;
            e_an = 4'hF; e_hex = 4'h0; e_le = 1'b1; e_point = 1'b0; e_tick = 1'b0;
        end else if (m_valid) begin
            dig     = m_pos / SD;
            off     = m_pos % SD;
            e_an    = (en && off >= BC) ? ~(4'b0001 << dig) : 4'hF;
            e_hex   = 4'((a_num >> (4 * (3 - dig))) & 16'h000F);
            e_point = a_pts[3 - dig];
            e_le    = a_les[3 - dig];
`ifdef DISP_BLINK_EN
            e_le    = e_le | (m_phase & a_blk[3 - dig]);
`endif
            fe      = en && (m_pos == FRAME - 1);
            e_tick  = fe;
            acc     = wr_if.wr_valid && !m_pending;
            if (fe && m_pending) begin
                a_num = s_num; a_pts = s_pts; a_les = s_les; a_blk = s_blk;
                m_pending = 1'b0;
            end else if (acc) begin
                s_num = wr_if.wr_num; s_pts = wr_if.wr_points;
                s_les = wr_if.wr_les; s_blk = wr_if.wr_blink;
                m_pending = 1'b1;
            end
            if (fe) begin
                m_bcnt++;
                if (m_bcnt == BF) begin
                    m_bcnt  = 0;
                    m_phase = ~m_phase;
                end
            end
            if (en) m_pos = (m_pos + 1) % FRAME;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("an",         16'(an),             16'(e_an));
            check("hex",        16'(hex),            16'(e_hex));
            check("le",         16'(le),             16'(e_le));
            check("point",      16'(point),          16'(e_point));
            check("frame_tick", 16'(frame_tick),     16'(e_tick));
            check("wr_ready",   16'(wr_if.wr_ready), 16'(!m_pending));
        end
    end

    task automatic do_write(input logic [15:0] num, input logic [3:0] pts,
                            input logic [3:0] les, input logic [3:0] blk);
        bit ok = 1'b0;
        wr_if.wr_num = num; wr_if.wr_points = pts; wr_if.wr_les = les; wr_if.wr_blink = blk;
        wr_if.wr_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (wr_if.wr_ready === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) timeout("write_accept");
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
        if (ok) check("wr_ready_drop", 16'(wr_if.wr_ready), 16'h0);
    endtask

    task automatic wait_tick(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) ok = 1'b1;
        end
        if (!ok) timeout(name);
    endtask

    task automatic wait_an(input logic [3:0] v, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (an === v) ok = 1'b1;
        end
        if (!ok) timeout(name);
    endtask

    task automatic wait_pos(input int p, input bit need_idle, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (m_pos == p && (!need_idle || !m_pending)) ok = 1'b1;
        end
        if (!ok) timeout(name);
    endtask

    logic [3:0] pin_an [10];
    logic [3:0] got_an [64];

    initial begin
        int n_ticks;
        int first_tick;
        int n_before;
        int n_e;
        bit found;
        pin_an = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF};
        rst = 1'b1; en = 1'b1;
        wr_if.wr_valid = 1'b0; wr_if.wr_num = 16'h0; wr_if.wr_points = 4'h0;
        wr_if.wr_les = 4'h0; wr_if.wr_blink = 4'h0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_an",    16'(an),             16'hF);
        check("rst_hex",   16'(hex),            16'h0);
        check("rst_le",    16'(le),             16'h1);
        check("rst_point", 16'(point),          16'h0);
        check("rst_tick",  16'(frame_tick),     16'h0);
        check("rst_ready", 16'(wr_if.wr_ready), 16'h1);
        rst = 1'b0;

        // Scan sequence and frame tick rate
        n_ticks = 0; first_tick = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            got_an[i] = an;
            if (frame_tick === 1'b1) begin
                n_ticks++;
                if (first_tick < 0) first_tick = i;
            end
        end
        for (int i = 0; i < 10; i++) check("scan_an_seq", 16'(got_an[i]), 16'(pin_an[i]));
        check("scan_an_slot1", 16'(got_an[10]), 16'hD);
        check("scan_an_slot3", 16'(got_an[31]), 16'h7);
        check("tick_count", 16'(n_ticks), 16'd2);
        check("tick_first", 16'(first_tick), 16'd31);

        // Write and commit
        repeat (10) @(negedge clk);
        do_write(16'h1234, 4'b0001, 4'b0000, 4'b0000);
        wait_tick("commit_tick");
        wait_an(4'hE, "an_e");
        check("d0_hex", 16'(hex), 16'h1);
        check("d0_le", 16'(le), 16'h0);
        check("d0_point", 16'(point), 16'h0);
        wait_an(4'hD, "an_d");
        check("d1_hex", 16'(hex), 16'h2);
        wait_an(4'hB, "an_b");
        check("d2_hex", 16'(hex), 16'h3);
        wait_an(4'h7, "an_7");
        check("d3_hex", 16'(hex), 16'h4);
        check("d3_point", 16'(point), 16'h1);
        check("ready_back", 16'(wr_if.wr_ready), 16'h1);

        // Back-pressure
        repeat (5) @(negedge clk);
        do_write(16'h5555, 4'b0000, 4'b0000, 4'b0000);
        do_write(16'hAAAA, 4'b0000, 4'b0000, 4'b0000);
        check("bp_hex_5", 16'(hex), 16'h5);
        wait_tick("bp_tick");
        wait_an(4'hE, "bp_an");
        check("bp_hex_a", 16'(hex), 16'hA);

        // Write on the frame-end cycle
        wait_pos(FRAME - 1, 1'b1, "fe_pos");
        do_write(16'hBEEF, 4'b1010, 4'b0000, 4'b0000);
        check("fe_tick", 16'(frame_tick), 16'h1);
        check("fe_hex_old", 16'(hex), 16'hA);
        wait_an(4'hE, "fe_an1");
        check("fe_hex_still_a", 16'(hex), 16'hA);
        wait_tick("fe_tick2");
        wait_an(4'hE, "fe_an2");
        check("fe_hex_b", 16'(hex), 16'hB);
        check("fe_point", 16'(point), 16'h1);

        // en low for 5 cycles mid-DRIVE of digit 0
        wait_pos(4, 1'b0, "en_pos");
        en = 1'b0; n_before = 0; n_e = 0; found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (k == 4) en = 1'b1;
            if (an === 4'hD) found = 1'b1;
            else begin
                n_before++;
                if (an === 4'hE) n_e++;
            end
        end
        if (!found) timeout("en_gap");
        check("en_dwell", 16'(n_before), 16'd11);
        check("en_e_count", 16'(n_e), 16'd4);

        // Blink mask on digit 0
        do_write(16'h0000, 4'h0, 4'h0, 4'b1000);
        repeat (6 * FRAME) @(negedge clk);

        // Reset mid-write discards pending data
        do_write(16'h7777, 4'hF, 4'h0, 4'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_an", 16'(an), 16'hF);
        check("rst2_le", 16'(le), 16'h1);
        check("rst2_ready", 16'(wr_if.wr_ready), 16'h1);
        rst = 1'b0;
        repeat (FRAME + 2) @(negedge clk);
        wait_an(4'hE, "rst2_an_e");
        check("rst2_hex", 16'(hex), 16'h0);
        check("rst2_le_d0", 16'(le), 16'h1);
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Scan controller and register front-end for the 4-digit 7-segment display path. It replaces free-running clkdiv bit selection with a timed scan state machine that inserts a per-digit blanking interval to suppress ghosting. Display contents (hex, point, LE) are double-buffered behind a valid/ready write port and committed only at frame boundaries. Outputs feed the MyMC14495 decoder and the board AN pins directly.

Parameters:
SCAN_DIV, 131072, total clk cycles per digit slot (BLANK + DRIVE); legal range 4..2^24.
BLANK_CYC, 1024, cycles at the start of each slot with all anodes off; legal range 0..SCAN_DIV-2.
BLINK_FRAMES, 64, frames per blink half-period; used only with DISP_BLINK_EN.

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous reset, active-high
en  in  1  scan enable; 0 = all anodes off, scan counters hold
wr_valid  in  1  write request
wr_ready  out  1  high when a write will be accepted
wr_num  in  16  four hex nibbles; [15:12] = digit 0
wr_points  in  4  decimal points; [3] = digit 0
wr_les  in  4  latch/blank enables; [3] = digit 0, 1 = blank
wr_blink  in  4  per-digit blink mask; [3] = digit 0; ignored without DISP_BLINK_EN
an  out  4  anode select, active-low
hex  out  4  nibble to decoder D3..D0
le  out  1  decoder LE
point  out  1  decoder point
frame_tick  out  1  one-cycle pulse at end of digit 3 slot

Behaviour:
- Reset (rst=1 at clk edge): state=BLANK, digit=0, cycle count=0, shadow and active registers cleared (num=0, points=0, les=4'hF, blink=0), pending=0. Outputs: an=4'hF, hex=0, le=1, point=0, frame_tick=0, wr_ready=1. Reset mid-frame or mid-write discards pending data.
- States: BLANK -> DRIVE -> BLANK. BLANK lasts BLANK_CYC cycles; DRIVE lasts SCAN_DIV-BLANK_CYC cycles. If BLANK_CYC=0, BLANK is skipped.
- At the end of DRIVE, digit increments mod 4 (3 -> 0 wraps). The last DRIVE cycle of digit 3 is the frame-end cycle.
- Digit k mapping in DRIVE:
  - an: k=0 4'hE, k=1 4'hD, k=2 4'hB, k=3 4'h7.
  - hex = active_num[15-4k -: 4]; le = active_les[3-k]; point = active_points[3-k].
- In BLANK: an=4'hF; hex, le, and point carry the upcoming digit's values.
- All outputs are registered and reflect the state/counter of the previous cycle (1-cycle latency).
- en=0: counters and state hold, an forced to 4'hF on the next cycle, frame_tick=0. Writes are still accepted; commit waits for a frame end.
- Write handshake:
  - wr_ready = ~pending.
  - On wr_valid & wr_ready, shadow <= wr_* and pending <= 1. wr_ready drops the next cycle.
  - wr_valid while wr_ready=0 is ignored (not queued); the requester must hold valid.
- Commit: on the frame-end cycle with pending=1, active <= shadow and pending <= 0. New values therefore first appear at the next digit 0 slot, so a frame never mixes old and new data.
- Write accepted on a frame-end cycle: pending was 0, so no commit occurs that cycle. The write commits at the following frame end.
- frame_tick pulses on the cycle after the frame-end cycle, coincident with the committed active values becoming visible.

Optional Feature:
Macro: DISP_BLINK_EN.
- Defined:
  - wr_blink is captured into shadow/active with the other fields.
  - blink_phase toggles every BLINK_FRAMES frame-ends; reset value 0 = on.
  - While blink_phase=1, any digit with active_blink bit set has le forced to 1.
- Undefined: wr_blink is ignored, no blink counter is built, le = active_les only.

Decomposition:
- Package disp_pkg holds:
  - scan state enum {BLANK, DRIVE};
  - AN_PATTERN constants 4'hE/4'hD/4'hB/4'h7;
  - default SCAN_DIV/BLANK_CYC/BLINK_FRAMES localparams;
  - a counter-width function based on $clog2(SCAN_DIV).
- Sub-module disp_scan_timer: cycle counter, BLANK/DRIVE state, 2-bit digit index, and the frame-end strobe.
- disp_scan_ctrl owns the register buffering, handshake, mux, and blink logic.

Test Plan:
- Reset scan (SCAN_DIV=8, BLANK_CYC=2, en=1): after reset, an sequence per slot is F,F then E x6, F,F, D x6, F,F, B x6, F,F, 7 x6. frame_tick pulses once per 32 cycles; all digits have le=1.
- Write and commit: write num=16'h1234, les=0, points=4'b0001 mid-frame. wr_ready drops next cycle. Display is unchanged until frame end; the next frame shows hex 1,2,3,4 on an E,D,B,7 with point=1 only on digit 3. wr_ready returns to 1.
- Back-pressure: hold wr_valid with num=16'hAAAA while pending. No acceptance until commit; accepted the cycle after frame end, committed one frame later.
- Write on frame-end cycle: accepted and not committed that cycle; it appears two frame boundaries after acceptance.
- en low mid-DRIVE for 5 cycles: an=4'hF during the gap; the slot resumes at the same count, and total digit dwell grows by exactly 5 cycles.
- DISP_BLINK_EN, BLINK_FRAMES=2, blink=4'b1000: digit 0 le alternates 0/1 every 2 frames; other digits are steady. Without the macro, digit 0 never blinks.
